frame_commit_buffer: RTL and testbench

FRAME_COMMIT_BUFFER -- requirements
Module: frame_commit_buffer

---
 rtl/frame_commit_buffer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_frame_commit_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_commit_buffer.sv
// Packs a dibit stream into words and holds each frame in a circular buffer.
// A frame becomes readable only after a good FCS verdict; otherwise it is rolled back.
module frame_commit_buffer #(
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  input  logic              fcs_done,
  input  logic              fcs_ok,
  output logic              axiov,
  output logic [WORD_W-1:0] axiod,
  output logic              axiol,
  input  logic              axioready,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DPW = WORD_W / 2;
  localparam int DW  = $clog2(DPW);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_FLUSH,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t state_reg, state_next;

  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, commit_ptr_reg, frame_start_reg;
  logic [WORD_W-1:0] word_reg;
  logic [DW-1:0]     dib_cnt_reg;
  logic [TW-1:0]     tmo_reg;
  logic              ovf_reg, vld_reg, ok_reg, pend_reg, sync_reg;
  logic [CNT_W-1:0]  good_cnt_reg, drop_cnt_reg, ovf_cnt_reg;
  logic              out_valid_reg, out_last_reg;
  logic [WORD_W-1:0] out_data_reg;

  logic [WORD_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];

  logic              take_dibit, flush_part, flush_mark, resolve, discard_done, latch_en;
  logic              frame_start_ev, word_done, word_wr, buf_full, mem_we, ovf_hit;
  logic              last_we, last_val, commit, rollback, tmo_max, rd_load;
  logic [AW-1:0]     last_addr;
  logic [WORD_W-1:0] wr_data, word_ins;

  // Drop the incoming dibit into its slot; untouched slots stay zero, which pads partial words.
  genvar gi;
  generate
    for (gi = 0; gi < DPW; gi++) begin : g_slot
      assign word_ins[WORD_W-1-2*gi -: 2] =
        (dib_cnt_reg == DW'(gi)) ? axiid : word_reg[WORD_W-1-2*gi -: 2];
    end
  endgenerate

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (axiiv) begin
          state_next = sync_reg ? S_RECV : S_DISCARD;
        end
      end
      S_RECV: begin
        if (!axiiv) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: state_next = S_WAIT;
      S_WAIT: begin
        if (axiiv) begin
          state_next = S_DISCARD;
        end else if (resolve) begin
          state_next = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (!axiiv) begin
          state_next = pend_reg ? S_WAIT : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    take_dibit   = 1'b0;
    flush_part   = 1'b0;
    flush_mark   = 1'b0;
    resolve      = 1'b0;
    discard_done = 1'b0;
    latch_en     = 1'b0;
    case (state_reg)
      S_IDLE: take_dibit = axiiv && sync_reg;
      S_RECV: begin
        take_dibit = axiiv;
        latch_en   = 1'b1;
      end
      S_FLUSH: begin
        flush_part = (dib_cnt_reg != '0);
        flush_mark = (dib_cnt_reg == '0);
        latch_en   = 1'b1;
      end
      S_WAIT: begin
        resolve  = !axiiv && (vld_reg || tmo_max);
        latch_en = 1'b1;
      end
      S_DISCARD: discard_done = !axiiv;
      default: ;
    endcase
  end

  assign tmo_max        = (tmo_reg == TW'(TIMEOUT - 1));
  assign frame_start_ev = take_dibit && (state_reg == S_IDLE);
  assign word_done      = take_dibit && (dib_cnt_reg == DW'(DPW - 1));
  assign buf_full       = ((wr_ptr_reg + AW'(1)) == rd_ptr_reg);
  assign word_wr        = (word_done || flush_part) && !ovf_reg;
  assign mem_we         = word_wr && !buf_full;
  assign ovf_hit        = word_wr && buf_full;
  assign wr_data        = flush_part ? word_reg : word_ins;
  // A frame ending on a word boundary already wrote its final word; revisit it to set last.
  assign last_we        = mem_we || (flush_mark && !ovf_reg);
  assign last_addr      = mem_we ? wr_ptr_reg : wr_ptr_reg - AW'(1);
  assign last_val       = flush_part || flush_mark;
  assign commit         = resolve && vld_reg && ok_reg && !ovf_reg;
  assign rollback       = resolve && !commit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg      <= '0;
      commit_ptr_reg  <= '0;
      frame_start_reg <= '0;
      word_reg        <= '0;
      dib_cnt_reg     <= '0;
      tmo_reg         <= '0;
      ovf_reg         <= 1'b0;
      vld_reg         <= 1'b0;
      ok_reg          <= 1'b0;
      pend_reg        <= 1'b0;
      sync_reg        <= 1'b0;
      good_cnt_reg    <= '0;
      drop_cnt_reg    <= '0;
      ovf_cnt_reg     <= '0;
    end else begin
      if (!axiiv) begin
        sync_reg <= 1'b1;
      end
      if (frame_start_ev) begin
        frame_start_reg <= wr_ptr_reg;
        ovf_reg         <= 1'b0;
        vld_reg         <= 1'b0;
        tmo_reg         <= '0;
      end
      if (take_dibit) begin
        if (word_done) begin
          word_reg    <= '0;
          dib_cnt_reg <= '0;
        end else begin
          word_reg    <= word_ins;
          dib_cnt_reg <= dib_cnt_reg + DW'(1);
        end
      end
      if (flush_part || flush_mark) begin
        word_reg    <= '0;
        dib_cnt_reg <= '0;
      end
      if (ovf_hit) begin
        ovf_reg <= 1'b1;
      end
      if (latch_en && fcs_done && !vld_reg) begin
        vld_reg <= 1'b1;
        ok_reg  <= fcs_ok;
      end
      // The pending frame's timer keeps running while an overlapping frame is discarded.
      if ((state_reg == S_WAIT || state_reg == S_DISCARD) && !tmo_max) begin
        tmo_reg <= tmo_reg + TW'(1);
      end
      if (state_reg == S_WAIT && axiiv) begin
        pend_reg <= 1'b1;
      end else if (state_reg == S_IDLE) begin
        pend_reg <= 1'b0;
      end
      if (mem_we) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (commit) begin
        commit_ptr_reg <= wr_ptr_reg;
        good_cnt_reg   <= sat_inc(good_cnt_reg);
      end
      if (rollback) begin
        wr_ptr_reg <= frame_start_reg;
        if (ovf_reg) begin
          ovf_cnt_reg <= sat_inc(ovf_cnt_reg);
        end
      end
      if (rollback || discard_done) begin
        drop_cnt_reg <= sat_inc(drop_cnt_reg);
      end
      if (resolve) begin
        vld_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      mem_data[wr_ptr_reg] <= wr_data;
    end
    if (rstn && last_we) begin
      mem_last[last_addr] <= last_val;
    end
  end

  assign rd_load = (rd_ptr_reg != commit_ptr_reg) && (!out_valid_reg || axioready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (rd_load) begin
      out_data_reg  <= mem_data[rd_ptr_reg];
      out_last_reg  <= mem_last[rd_ptr_reg];
      out_valid_reg <= 1'b1;
      rd_ptr_reg    <= rd_ptr_reg + AW'(1);
    end else if (axioready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign axiov    = out_valid_reg;
  assign axiod    = out_data_reg;
  assign axiol    = out_last_reg;
  assign good_cnt = good_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign ovf_cnt  = ovf_cnt_reg;

endmodule

// File: tb/tb_frame_commit_buffer.sv
// Directed bench for frame_commit_buffer: small buffer and short timeout so
// overflow and timeout paths are reachable in a few hundred cycles.
module tb_frame_commit_buffer;

  localparam int WORD_W  = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rstn, axiiv, fcs_done, fcs_ok, axioready;
  logic [1:0]        axiid;
  logic              axiov, axiol;
  logic [WORD_W-1:0] axiod;
  logic [CNT_W-1:0]  good_cnt, drop_cnt, ovf_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  frame_commit_buffer #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .axiiv(axiiv), .axiid(axiid),
    .fcs_done(fcs_done), .fcs_ok(fcs_ok),
    .axiov(axiov), .axiod(axiod), .axiol(axiol), .axioready(axioready),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    $display("[%0t] %s obs=%0h exp=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int n, input logic [1:0] d, input bit counting);
    for (int i = 0; i < n; i++) begin
      axiiv = 1'b1;
      axiid = counting ? 2'(i) : d;
      tick(1);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
  endtask

  task automatic verdict(input logic ok);
    fcs_done = 1'b1;
    fcs_ok   = ok;
    tick(1);
    fcs_done = 1'b0;
    fcs_ok   = 1'b0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 40 && axiov !== 1'b1; n++) begin
      tick(1);
    end
  endtask

  // Assumes axioready=1 so the trailing tick consumes the word.
  task automatic expect_word(input string tag, input logic [WORD_W-1:0] data, input logic last);
    wait_valid();
    check({tag, "_v"}, axiov, 1);
    check({tag, "_d"}, axiod, data);
    check({tag, "_l"}, axiol, last);
    tick(1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_axiov"}, axiov, 0);
    check({tag, "_axiod"}, axiod, 0);
    check({tag, "_axiol"}, axiol, 0);
    check({tag, "_good"}, good_cnt, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_ovf"}, ovf_cnt, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; axiiv = 1'b0; axiid = 2'b00;
    fcs_done = 1'b0; fcs_ok = 1'b0; axioready = 1'b1;
    tick(3);
    check_zero_outputs("rst");
    rstn = 1'b1;
    tick(2);

    // Single full word; commit edge then valid one cycle later
    send_frame(16, 2'b10, 0);
    verdict(1);
    tick(2);
    check("t1_good_at_commit", good_cnt, 1);
    check("t1_not_yet_valid", axiov, 0);
    tick(1);
    check("t1_valid_next", axiov, 1);
    expect_word("t1", 32'hAAAAAAAA, 1'b1);
    tick(2);
    check("t1_empty", axiov, 0);

    // One full word plus a 4-dibit padded tail, read back-to-back
    send_frame(20, 2'b11, 0);
    verdict(1);
    expect_word("t2a", 32'hFFFFFFFF, 1'b0);
    check("t2_b2b", axiov, 1);
    expect_word("t2b", 32'hFF000000, 1'b1);
    check("t2_good", good_cnt, 2);

    // Bad FCS rolls back; next frame reuses the same slots
    send_frame(64, 2'b01, 0);
    verdict(0);
    tick(6);
    check("t3_noout", axiov, 0);
    check("t3_drop", drop_cnt, 1);
    check("t3_good", good_cnt, 2);
    send_frame(16, 2'b00, 1);
    verdict(1);
    expect_word("t3_next", 32'h1B1B1B1B, 1'b1);

    // 17-word frame into 15 free slots overflows and is dropped despite good FCS
    axioready = 1'b0;
    send_frame(272, 2'b10, 0);
    verdict(1);
    tick(4);
    check("t4_ovf", ovf_cnt, 1);
    check("t4_drop", drop_cnt, 2);
    check("t4_good", good_cnt, 3);
    check("t4_noout", axiov, 0);

    // Short 3-dibit frame held stable under backpressure
    send_frame(3, 2'b11, 0);
    verdict(1);
    wait_valid();
    check("t4h_v", axiov, 1);
    check("t4h_d", axiod, 32'hFC000000);
    tick(3);
    check("t4h_hold_v", axiov, 1);
    check("t4h_hold_d", axiod, 32'hFC000000);
    check("t4h_hold_l", axiol, 1);
    axioready = 1'b1;
    tick(1);
    check("t4h_taken", axiov, 0);
    check("t4h_good", good_cnt, 4);

    // No verdict: drop lands exactly on the 8th WAIT cycle; late strobe in IDLE ignored
    send_frame(16, 2'b10, 0);
    tick(2);
    tick(7);
    check("t5_pre_timeout", drop_cnt, 2);
    tick(1);
    check("t5_timeout", drop_cnt, 3);
    verdict(1);
    tick(3);
    check("t5_late_ignored", good_cnt, 4);
    check("t5_noout", axiov, 0);

    // Overlapping frame with verdict already latched: overlap dropped, pending committed
    send_frame(16, 2'b10, 0);
    verdict(1);
    tick(1);
    send_frame(5, 2'b11, 0);
    expect_word("t6", 32'hAAAAAAAA, 1'b1);
    check("t6_drop", drop_cnt, 4);
    check("t6_good", good_cnt, 5);
    tick(3);
    check("t6_nob", axiov, 0);

    // Overlap without a latched verdict: strobe during DISCARD ignored, pending times out
    send_frame(16, 2'b01, 0);
    tick(2);
    send_frame(4, 2'b11, 0);
    verdict(1);
    tick(12);
    check("t6b_drop", drop_cnt, 6);
    check("t6b_good", good_cnt, 5);
    check("t6b_noout", axiov, 0);

    // Reset mid-frame with 3 committed unread words
    axioready = 1'b0;
    send_frame(48, 2'b01, 0);
    verdict(1);
    tick(4);
    check("t7_pend", axiov, 1);
    axiiv = 1'b1;
    axiid = 2'b10;
    tick(5);
    rstn = 1'b0;
    tick(2);
    check_zero_outputs("t7_rst");
    rstn = 1'b1;
    tick(3);
    axiiv = 1'b0;
    tick(2);
    check("t7_discard_drop", drop_cnt, 1);
    check("t7_good0", good_cnt, 0);
    axioready = 1'b1;
    tick(3);
    check("t7_flushed", axiov, 0);
    send_frame(16, 2'b00, 1);
    verdict(1);
    expect_word("t7_word", 32'h1B1B1B1B, 1'b1);
    tick(4);
    check("t7_only_one", axiov, 0);
    check("t7_good1", good_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
